// File: rtl/stream_credit_pkg.sv
// Shared types and constants for the credit-based stream sender.
package stream_credit_pkg;

    // Link control states: forwarding beats, waiting for credits to return, quiesced.
    typedef enum logic [1:0] {
        Run     = 2'd0,
        Drain   = 2'd1,
        Drained = 2'd2
    } credit_state_e;

    localparam int unsigned StallCntWidth = 32;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down counter with synchronous clear to a programmable initial value.
// Holds at Max on increment (flagging ovf_pulse) and at zero on decrement.
module credit_counter #(
    parameter int unsigned     Width = 4,
    parameter logic [Width-1:0] Max  = '1,
    parameter logic [Width-1:0] Init = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [Width-1:0] count,
    output logic [Width-1:0] next_count,
    output logic             ovf_pulse
);

    // Next-count selection: clear wins, simultaneous inc/dec cancel, both ends saturate.
    always_comb begin
        next_count = count;
        ovf_pulse  = 1'b0;
        if (clr) begin
            next_count = Init;
        end else if (inc && !dec) begin
            if (count == Max) begin
                ovf_pulse = 1'b1;
            end else begin
                next_count = count + Width'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                next_count = count - Width'(1);
            end
        end
    end

    // Count register, reset to the initial value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= Init;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/stream_credit_sender.sv
// Transmit end of a credit-based stream link. Converts a valid/ready stream into a
// registered valid-only beat stream, spending one credit per beat and regaining one
// per credit_i pulse. Includes a drain handshake for quiescing the link.
// Optional stall statistics are built when STREAM_CREDIT_SENDER_STATS_EN is defined;
// otherwise stall_cnt_o is tied to zero.
module stream_credit_sender
    import stream_credit_pkg::*;
#(
    parameter int unsigned NumCredits = 8,
    parameter type         type_t     = logic,
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  type_t                    data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output type_t                    data_o,
    output logic                     valid_o,
    input  logic                     credit_i,
    output logic [CntWidth-1:0]      credits_o,
    input  logic                     drain_req_i,
    output logic                     drain_ack_o,
    output logic                     err_o,
    output logic [StallCntWidth-1:0] stall_cnt_o
);

    localparam logic [CntWidth-1:0] MaxCredits = CntWidth'(NumCredits);

    credit_state_e       state;
    credit_state_e       state_next;
    logic                hs;
    logic [CntWidth-1:0] credits_next;
    logic                credit_ovf;

    // Upstream may only hand over a beat when running, a remote slot is free and no flush.
    assign ready_o = (state == Run) && (credits_o != '0) && !flush_i;
    assign hs      = valid_i && ready_o;

    credit_counter #(
        .Width (CntWidth),
        .Max   (MaxCredits),
        .Init  (MaxCredits)
    ) u_credit_counter (
        .clk        (clk_i),
        .rst        (rst_i),
        .inc        (credit_i),
        .dec        (hs),
        .clr        (flush_i),
        .count      (credits_o),
        .next_count (credits_next),
        .ovf_pulse  (credit_ovf)
    );

    // Output beat register; data holds its last value when no beat is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= hs;
            if (hs) begin
                data_o <= data_i;
            end
        end
    end

    // Sticky overflow flag: a credit came back while all credits were already held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (flush_i) begin
            err_o <= 1'b0;
        end else if (credit_ovf) begin
            err_o <= 1'b1;
        end
    end

    // Drain FSM next state; drained is declared as soon as the count returns to full.
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = Run;
        end else begin
            unique case (state)
                Run: begin
                    if (drain_req_i) begin
                        state_next = Drain;
                    end
                end
                Drain: begin
                    if (!drain_req_i) begin
                        state_next = Run;
                    end else if (credits_next == MaxCredits) begin
                        state_next = Drained;
                    end
                end
                Drained: begin
                    if (!drain_req_i) begin
                        state_next = Run;
                    end
                end
                default: state_next = Run;
            endcase
        end
    end

    // State and registered drain acknowledge, kept in step with each other.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= Run;
            drain_ack_o <= 1'b0;
        end else begin
            state       <= state_next;
            drain_ack_o <= (state_next == Drained);
        end
    end

`ifdef STREAM_CREDIT_SENDER_STATS_EN
    logic                     stall;
    logic [StallCntWidth-1:0] stall_cnt_next;
    logic                     stall_cnt_sat;

    // Upstream has data but no credit is available while the link is running.
    assign stall = valid_i && !ready_o && (state == Run);

    credit_counter #(
        .Width (StallCntWidth),
        .Max   ({StallCntWidth{1'b1}}),
        .Init  ('0)
    ) u_stall_counter (
        .clk        (clk_i),
        .rst        (rst_i),
        .inc        (stall),
        .dec        (1'b0),
        .clr        (flush_i),
        .count      (stall_cnt_o),
        .next_count (stall_cnt_next),
        .ovf_pulse  (stall_cnt_sat)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_credit_sender.sv
// Directed self-checking bench for stream_credit_sender with NumCredits = 4.
module tb_stream_credit_sender;

    localparam int unsigned NumCredits = 4;
    localparam int unsigned CntWidth   = $clog2(NumCredits + 1);
`ifdef STREAM_CREDIT_SENDER_STATS_EN
    localparam logic [31:0] ExpStall = 32'd10;
`else
    localparam logic [31:0] ExpStall = 32'd0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic [7:0]          data_in = '0;
    logic                valid_in = 1'b0;
    logic                ready;
    logic [7:0]          data_out;
    logic                valid_out;
    logic                credit = 1'b0;
    logic [CntWidth-1:0] credits;
    logic                drain_req = 1'b0;
    logic                drain_ack;
    logic                err;
    logic [31:0]         stall_cnt;

    int n_checks = 0;
    int n_bad    = 0;

    stream_credit_sender #(
        .NumCredits (NumCredits),
        .type_t     (logic [7:0])
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .data_i      (data_in),
        .valid_i     (valid_in),
        .ready_o     (ready),
        .data_o      (data_out),
        .valid_o     (valid_out),
        .credit_i    (credit),
        .credits_o   (credits),
        .drain_req_i (drain_req),
        .drain_ack_o (drain_ack),
        .err_o       (err),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #12;
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ack", 32'(drain_ack), 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_ready", 32'(ready), 32'd1);

        // Burst of 4 beats until credits run out
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'hA + 8'(i);
            #1;
            check("burst_ready", 32'(ready), 32'd1);
            tick();
            check("burst_valid", 32'(valid_out), 32'd1);
            check("burst_data", 32'(data_out), 32'(8'hA + 8'(i)));
            check("burst_credits", 32'(credits), 32'(3 - i));
        end
        data_in = 8'hEE;
        #1;
        check("empty_ready", 32'(ready), 32'd0);
        tick();
        check("empty_valid", 32'(valid_out), 32'd0);
        check("empty_credits", 32'(credits), 32'd0);
        check("hold_data", 32'(data_out), 32'h0D);

        // Each returned credit lets exactly one beat through
        for (int i = 0; i < 4; i++) begin
            credit  = 1'b1;
            data_in = 8'h10 + 8'(i);
            tick();
            credit = 1'b0;
            #1;
            check("ret_credits", 32'(credits), 32'd1);
            check("ret_ready", 32'(ready), 32'd1);
            check("ret_novalid", 32'(valid_out), 32'd0);
            tick();
            check("ret_valid", 32'(valid_out), 32'd1);
            check("ret_data", 32'(data_out), 32'(8'h10 + 8'(i)));
            check("ret_credits0", 32'(credits), 32'd0);
        end

        // Handshake and credit return together at credits==1
        credit = 1'b1;
        data_in = 8'h30;
        tick();
        check("one_credits", 32'(credits), 32'd1);
        data_in = 8'h31;
        tick();
        check("simul_credits", 32'(credits), 32'd1);
        check("simul_valid", 32'(valid_out), 32'd1);
        check("simul_data", 32'(data_out), 32'h31);
        credit  = 1'b0;
        data_in = 8'h32;
        #1;
        check("simul_ready", 32'(ready), 32'd1);
        tick();
        check("simul_next_valid", 32'(valid_out), 32'd1);
        check("simul_next_data", 32'(data_out), 32'h32);
        check("simul_next_credits", 32'(credits), 32'd0);
        valid_in = 1'b0;

        // Overflow flag is sticky until flush
        do_reset();
        credit = 1'b1;
        tick();
        credit = 1'b0;
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_credits", 32'(credits), 32'd4);
        tick();
        check("ovf_sticky", 32'(err), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_err", 32'(err), 32'd0);
        check("flush_credits", 32'(credits), 32'd4);

        // Flush blocks the handshake and drops the next beat
        valid_in = 1'b1;
        data_in  = 8'h40;
        tick();
        check("pre_flush_valid", 32'(valid_out), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(ready), 32'd0);
        tick();
        flush    = 1'b0;
        valid_in = 1'b0;
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_credits2", 32'(credits), 32'd4);

        // Drain with 3 credits in flight
        valid_in = 1'b1;
        tick();
        tick();
        tick();
        valid_in = 1'b0;
        check("drain_pre_credits", 32'(credits), 32'd1);
        drain_req = 1'b1;
        tick();
        check("drain_ready", 32'(ready), 32'd0);
        check("drain_ack0", 32'(drain_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            credit = 1'b1;
            tick();
            credit = 1'b0;
            check("drain_credits", 32'(credits), 32'(2 + i));
            check("drain_ack", 32'(drain_ack), (i == 2) ? 32'd1 : 32'd0);
        end
        check("drained_ready", 32'(ready), 32'd0);
        drain_req = 1'b0;
        tick();
        check("undrain_ack", 32'(drain_ack), 32'd0);
        check("undrain_ready", 32'(ready), 32'd1);

        // Asynchronous reset while a beat is on the output
        valid_in = 1'b1;
        data_in  = 8'h55;
        tick();
        valid_in = 1'b0;
        check("arst_pre_valid", 32'(valid_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid_out), 32'd0);
        check("arst_credits", 32'(credits), 32'd4);
        #1;
        rst = 1'b0;
        tick();
        check("arst_idle", 32'(valid_out), 32'd0);
        valid_in = 1'b1;
        data_in  = 8'h66;
        tick();
        valid_in = 1'b0;
        check("arst_first_valid", 32'(valid_out), 32'd1);
        check("arst_first_data", 32'(data_out), 32'h66);

        // Stall statistics: 4 handshakes, then 10 stalled cycles
        do_reset();
        valid_in = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        valid_in = 1'b0;
        #1;
        check("stall_cnt", stall_cnt, ExpStall);
        check("stall_credits", 32'(credits), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_credit_sender.md
Name: stream_credit_sender

Overview:
- Transmit end of a credit-based stream link; turns a local valid/ready stream into a valid-only beat stream toward a remote receive buffer of known depth.
- Holds one credit per free remote slot; consumes a credit per beat sent and regains one per credit_i pulse from the remote.
- Sits at the upstream end of long or pipelined links, where remote backpressure cannot be carried combinationally.
- Provides a drain handshake so software/control can quiesce the link before reconfiguration.

Parameters:
- NumCredits, 8, remote buffer depth and reset credit count; legal range 1..2**16.
- type_t, logic, payload type.
- CntWidth, $clog2(NumCredits+1), derived; do not overwrite.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush (see Behaviour).
- data_i  in  type_t  upstream payload.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  type_t  link payload, registered.
- valid_o  out  1  link beat strobe, registered, one cycle per beat, no backpressure.
- credit_i  in  1  one credit returned per high cycle.
- credits_o  out  CntWidth  credits currently available.
- drain_req_i  in  1  level request to quiesce.
- drain_ack_o  out  1  high while drained.
- err_o  out  1  sticky: credit returned while counter already at NumCredits.
- stall_cnt_o  out  32  stall statistics (Optional Feature).

Behaviour:
- Reset values (rst_i high, asynchronous):
  - credits = NumCredits.
  - valid_o = 0, data_o = '0.
  - state = RUN.
  - err_o = 0, drain_ack_o = 0, stall_cnt_o = 0.
- ready_o = (state==RUN) && (credits != 0) && !flush_i. Combinational; never depends on valid_i.
- Handshake: valid_i && ready_o.
  - Next cycle: valid_o = 1 and data_o = data_i.
  - Otherwise valid_o = 0 next cycle, and data_o holds its last value.
  - Latency is one cycle; throughput is one beat per cycle while credits remain.
- Counter update each cycle: credits_next = credits - hs + credit_i.
  - Handshake and credit_i in the same cycle leave the count unchanged.
  - Handshake at credits==1 with credit_i high: count stays 1, ready_o stays high.
- Overflow: credit_i with credits==NumCredits and no handshake: count saturates at NumCredits and err_o is set.
  - err_o clears only on rst_i or flush_i.
- credits_o reflects the registered count; never exceeds NumCredits, never wraps below 0.
- FSM states: RUN, DRAIN, DRAINED.
  - RUN -> DRAIN when drain_req_i=1.
  - DRAIN: ready_o=0; accepted beat already in the output register still issues.
  - DRAIN -> DRAINED when credits_next == NumCredits (includes the same cycle it is reached).
  - DRAINED: drain_ack_o=1 (registered), ready_o=0.
  - DRAINED -> RUN when drain_req_i=0. drain_ack_o drops in the same transition.
  - DRAIN -> RUN if drain_req_i falls before drained.
- flush_i: next cycle credits=NumCredits, valid_o=0, err_o=0, state=RUN. No beat is accepted in the flush cycle.
  - The remote buffer must be flushed in the same cycle; this is a system requirement, not checked by the block.
- Reset mid-beat: a pending valid_o is dropped immediately (asynchronous); no partial beat.

Optional Feature:
- Macro STREAM_CREDIT_SENDER_STATS_EN.
- Defined: stall_cnt_o counts cycles with valid_i=1 && ready_o=0 && state==RUN.
  - 32-bit counter, saturating at 2**32-1.
  - Cleared by rst_i or flush_i.
- Undefined: no counter logic; stall_cnt_o tied to '0. Port list is unchanged.

Decomposition:
- Package stream_credit_pkg:
  - enum credit_state_e {RUN, DRAIN, DRAINED}.
  - localparam StallCntWidth = 32.
- Sub-module credit_counter: saturating up/down counter.
  - Parameters: Max, Width.
  - Inputs: inc, dec, clr.
  - Outputs: count, next_count, ovf_pulse.
  - Instantiated once; the stats counter reuses it with Max = 2**32-1 and no dec.

Test Plan:
- NumCredits=4, valid_i high continuously, no credit_i: 4 beats issue on consecutive cycles with data 0xA..0xD, then ready_o=0 and credits_o=0. Credits returned one per cycle on credit_i give 4 more beats, each beat one cycle after its credit.
- credits_o=1, valid_i=1 and credit_i=1 in the same cycle: beat accepted, credits_o stays 1, next beat accepted the following cycle.
- Reset state (credits_o=4), credit_i pulse with valid_i=0: err_o=1 and stays 1, credits_o=4. Then flush_i pulse: err_o=0.
- 3 credits in flight, drain_req_i=1: ready_o=0 next cycle. After 3 credit_i pulses drain_ack_o=1 with credits_o=4. drain_req_i=0 -> RUN, ready_o=1.
- Assert rst_i asynchronously between clock edges while valid_o=1: valid_o=0 immediately, credits_o=NumCredits. After release, the first handshake yields valid_o one cycle later.
- STREAM_CREDIT_SENDER_STATS_EN defined, credits=0, valid_i high for 10 cycles: stall_cnt_o=10. With the macro undefined, stall_cnt_o=0.
